// File: rtl/led_seq_ctrl.sv
// LED bank sequencer: plays an 8-entry pattern/duration table on a prescaled tick,
// with global 4-bit PWM brightness and a static pattern shown while idle.
module led_seq_ctrl #(
  parameter logic [15:0] PRESC_INIT  = 16'd49999,
  parameter logic [7:0]  STATIC_INIT = 8'h0f
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_we,
  input  logic [3:0]  cfg_addr,
  input  logic [31:0] cfg_wdata,
  output logic [7:0]  led,
  output logic        busy,
  output logic [2:0]  cur_idx,
  output logic        seq_done
);

  localparam int unsigned NENT = 8;
  localparam int unsigned PW   = 16;
  localparam int unsigned DW   = 8;

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state_q, state_n;
  logic [2:0]      idx_q, idx_n;
  logic [DW-1:0]   dcnt_q, dcnt_n;
  logic [PW-1:0]   pcnt_q, pcnt_n;
  logic [3:0]      pwm_q;
  logic            done_n;

  logic            loop_q;
  logic [2:0]      last_q;
  logic [3:0]      bright_q;
  logic [PW-1:0]   presc_q;
  logic [7:0]      static_q;
  logic [7:0]      pat_q [NENT];
  logic [DW-1:0]   dur_q [NENT];

  logic            wr_ctrl, wr_presc, wr_static, wr_entry;
  logic [2:0]      wr_sel;
  logic            start_c, stop_c, tick_c;
  logic [DW-1:0]   dur_m1;
  logic [7:0]      static_n, base_n, led_n;
  logic [3:0]      bright_n;
  logic            unused_wdata;

  assign unused_wdata = ^{cfg_wdata[31:16], cfg_wdata[3]};

  // Register write decode
  always_comb begin
    wr_ctrl   = cfg_we && (cfg_addr == 4'h0);
    wr_presc  = cfg_we && (cfg_addr == 4'h1);
    wr_static = cfg_we && (cfg_addr == 4'h2);
    wr_entry  = cfg_we && cfg_addr[3];
    wr_sel    = cfg_addr[2:0];
    start_c   = wr_ctrl && cfg_wdata[0];
    stop_c    = wr_ctrl && cfg_wdata[1];
  end

  // Configuration and pattern table storage
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      loop_q   <= 1'b0;
      last_q   <= 3'd7;
      bright_q <= 4'd15;
      presc_q  <= PRESC_INIT;
      static_q <= STATIC_INIT;
      for (int i = 0; i < NENT; i++) begin
        pat_q[i] <= 8'h00;
        dur_q[i] <= '0;
      end
    end else begin
      if (wr_ctrl) begin
        loop_q   <= cfg_wdata[2];
        last_q   <= cfg_wdata[6:4];
        bright_q <= cfg_wdata[11:8];
      end
      if (wr_presc)  presc_q  <= cfg_wdata[15:0];
      if (wr_static) static_q <= cfg_wdata[7:0];
      if (wr_entry) begin
        pat_q[wr_sel] <= cfg_wdata[7:0];
        dur_q[wr_sel] <= cfg_wdata[15:8];
      end
    end
  end

  // Sequencer next-state; stop overrides both start and natural completion
  always_comb begin
    state_n = state_q;
    idx_n   = idx_q;
    dcnt_n  = dcnt_q;
    pcnt_n  = pcnt_q;
    done_n  = 1'b0;
    tick_c  = (state_q == RUN) && (pcnt_q >= presc_q);
    dur_m1  = (dur_q[idx_q] == '0) ? '0 : DW'(dur_q[idx_q] - DW'(1));

    case (state_q)
      IDLE: begin
        if (start_c) begin
          state_n = RUN;
          idx_n   = 3'd0;
          dcnt_n  = '0;
          pcnt_n  = '0;
        end
      end
      RUN: begin
        pcnt_n = tick_c ? '0 : PW'(pcnt_q + PW'(1));
        if (tick_c) begin
          if (dcnt_q >= dur_m1) begin
            dcnt_n = '0;
            if (idx_q != last_q) begin
              idx_n = 3'(idx_q + 3'd1);
            end else if (loop_q) begin
              idx_n = 3'd0;
            end else begin
              state_n = IDLE;
              idx_n   = 3'd0;
              done_n  = 1'b1;
            end
          end else begin
            dcnt_n = DW'(dcnt_q + DW'(1));
          end
        end
        if (start_c) begin
          state_n = RUN;
          idx_n   = 3'd0;
          dcnt_n  = '0;
          pcnt_n  = '0;
        end
      end
      default: state_n = IDLE;
    endcase

    if (stop_c) begin
      state_n = IDLE;
      idx_n   = 3'd0;
      dcnt_n  = '0;
      pcnt_n  = '0;
      done_n  = 1'b0;
    end
  end

  // LED drive uses post-write values so register writes show one cycle later
  always_comb begin
    static_n = wr_static ? cfg_wdata[7:0] : static_q;
    bright_n = wr_ctrl ? cfg_wdata[11:8] : bright_q;
    if (state_n == RUN)
      base_n = (wr_entry && (wr_sel == idx_n)) ? cfg_wdata[7:0] : pat_q[idx_n];
    else
      base_n = static_n;
    led_n = base_n & {8{pwm_q <= bright_n}};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      idx_q    <= 3'd0;
      dcnt_q   <= '0;
      pcnt_q   <= '0;
      pwm_q    <= 4'd0;
      led      <= STATIC_INIT;
      seq_done <= 1'b0;
    end else begin
      state_q  <= state_n;
      idx_q    <= idx_n;
      dcnt_q   <= dcnt_n;
      pcnt_q   <= pcnt_n;
      pwm_q    <= 4'(pwm_q + 4'd1);
      led      <= led_n;
      seq_done <= done_n;
    end
  end

  assign busy    = (state_q == RUN);
  assign cur_idx = idx_q;

endmodule
